data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Sits between the MEM stage and the synchronous data memory; a second requester port serves a program loader or debug agent.
- Sequences every access: round-robin grant, misalignment check, driving of the memory's write/read enables, funct3, address and write data.
- Returns load data one cycle later, byte/half extracted and sign- or zero-extended per funct3.
- After reset, optionally clears the whole memory before accepting requests.

Parameters:
- DATA_WIDTH, 32, data/address width (from defines).
- DATA_MEM_DEPTH, 1024, memory depth in words (from defines).
- DATA_MEM_ADDR_WIDTH, $clog2(DATA_MEM_DEPTH), word-index width (from defines).
- CLEAR_ON_RESET, 1, when 1, write zero to every word after reset release.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  2  request valid per port (bit 0 core, bit 1 loader).
- req_ready_o  out  2  grant/accept per port.
- req_we_i  in  2  per port, 1 = store, 0 = load.
- req_funct3_i  in  2x3  per-port funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- req_addr_i  in  2xDATA_WIDTH  per-port byte address.
- req_wdata_i  in  2xDATA_WIDTH  per-port store data, LSB-aligned.
- resp_valid_o  out  2  one-cycle response pulse to the requester.
- resp_rdata_o  out  DATA_WIDTH  formatted load data; 0 for stores/errors.
- resp_err_o  out  1  misaligned access, qualified by resp_valid_o.
- init_done_o  out  1  high once clearing is finished.
- mem_we_o  out  1  to data memory MemWrite_en.
- mem_re_o  out  1  to data memory MemRead_en.
- mem_funct3_o  out  3  to MEM_funct3_i.
- mem_addr_o  out  DATA_WIDTH  to rd_addr_i.
- mem_wdata_o  out  DATA_WIDTH  to wr_data_i.
- mem_rdata_i  in  DATA_WIDTH  from rd_data_o; valid the cycle after mem_re_o.

Behaviour:
- Reset values: req_ready_o=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_we_o=0, mem_re_o=0, init_done_o=0, rr pointer = port 0; state INIT if CLEAR_ON_RESET else RUN.
- INIT:
  - A word counter runs 0..DATA_MEM_DEPTH-1, one word per cycle: mem_we_o=1, funct3=SW, addr=cnt<<2, wdata=0.
  - req_ready_o=0 throughout.
  - After the last word, go to RUN; init_done_o=1 from the first RUN cycle.
- RUN, arbitration (combinational in cycle T):
  - If only one port is valid, grant it.
  - If both are valid, grant the port not granted last; the rr pointer updates only on a grant.
  - req_ready_o is one-hot on the granted port; a transfer is valid&ready.
- Alignment:
  - LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops are always aligned.
  - Misaligned: no mem_we_o/mem_re_o; error response in T+1.
  - Undefined funct3: treated as misaligned.
- Issue (cycle T):
  - Aligned store: mem_we_o=1. Aligned load: mem_re_o=1.
  - Address, funct3 and data are passed through from the granted port.
- Response register (captured at T): granted id, funct3, addr[1:0], err, is_load.
- Response (cycle T+1): resp_valid_o[id]=1 for exactly one cycle. For loads, rdata is the lane of mem_rdata_i selected by addr[1:0]:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: the full word.
- Throughput: a new grant is allowed in T+1 while the previous response is presented; back-to-back accesses give 1 access/cycle.
- No response backpressure: requesters must accept resp_valid_o.
- Store followed by a load to the same word: the load issues at T+1 and sees the stored data (memory write completes at the T edge).
- Reset mid-operation (in INIT or RUN): outputs return to reset values immediately; any pending response is dropped; INIT restarts from word 0.

Decomposition:
- Package defines already holds the FUNCT3_* load/store constants, DATA_WIDTH, DATA_MEM_DEPTH and DATA_MEM_ADDR_WIDTH.
- Add to defines: typedef enum logic [0:0] {ARB_INIT, ARB_RUN} arb_state_e; constant ARB_PORTS = 2.
- One combinational sub-module, load_formatter (funct3, byte offset, raw word -> extended word), reused later by the MEM stage.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> 16 consecutive mem_we_o cycles, addr 0x00..0x3C, wdata 0, then init_done_o=1 and req_ready_o usable.
- Core SW 0x80FF7F01 @0x10, then LB @0x11 -> LB response 0x0000007F.
  - LB @0x13 -> 0xFFFFFF80.
  - LHU @0x12 -> 0x000080FF.
  - LW -> 0x80FF7F01.
  - resp_valid_o[0] each one cycle after its grant.
- Both ports continuously valid for 6 cycles -> grants alternate 0,1,0,1,0,1; responses carry the matching id.
- Core LW @0x0000_0006 -> no mem enable, resp_err_o=1, resp_rdata_o=0 next cycle; SH @0x5 likewise.
- Loader SB 0xAA @0x20, core LBU @0x20 in the next cycle -> core reads 0x000000AA.
- Assert rst_n low mid-INIT (counter=7) and mid-read -> outputs zero immediately; after release INIT restarts at addr 0; the dropped read gives no resp_valid_o.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared widths, funct3 codes, arbiter state type and alignment helper
package data_mem_arbiter_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int DATA_MEM_DEPTH      = 1024;
  localparam int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH);
  localparam int ARB_PORTS           = 2;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [0:0] {ARB_INIT, ARB_RUN} arb_state_e;

  // Undefined funct3 codes report as not ok, so they share the misaligned path.
  function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] byte_off);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (funct3)
        FUNCT3_SB: ok = 1'b1;
        FUNCT3_SH: ok = ~byte_off[0];
        FUNCT3_SW: ok = (byte_off == 2'b00);
        default:   ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        FUNCT3_LB, FUNCT3_LBU: ok = 1'b1;
        FUNCT3_LH, FUNCT3_LHU: ok = ~byte_off[0];
        FUNCT3_LW:             ok = (byte_off == 2'b00);
        default:               ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_load_formatter.sv
// rtl/data_mem_arbiter_load_formatter.sv - byte/half lane extraction with sign or zero extension
module load_formatter
  import data_mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       byte_off,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = raw >> {byte_off, 3'b000};
    data    = '0;
    case (funct3)
      FUNCT3_LB:  data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      FUNCT3_LW:  data = raw;
      FUNCT3_LBU: data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      FUNCT3_LHU: data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin sequencer in front of the synchronous data memory
module data_mem_arbiter #(
  parameter int DATA_WIDTH          = data_mem_arbiter_pkg::DATA_WIDTH,
  parameter int DATA_MEM_DEPTH      = data_mem_arbiter_pkg::DATA_MEM_DEPTH,
  parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH),
  parameter bit CLEAR_ON_RESET      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [5:0]              req_funct3_i,
  input  logic [2*DATA_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  output logic [1:0]              resp_valid_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    resp_err_o,
  output logic                    init_done_o,
  output logic                    mem_we_o,
  output logic                    mem_re_o,
  output logic [2:0]              mem_funct3_o,
  output logic [DATA_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  import data_mem_arbiter_pkg::*;

  arb_state_e                     state, state_n;
  logic [DATA_MEM_ADDR_WIDTH-1:0] cnt;
  logic                           last_word;
  logic                           rr_ptr;
  logic                           gnt_any, gnt_id;
  logic                           g_we, g_ok;
  logic [2:0]                     g_funct3;
  logic [DATA_WIDTH-1:0]          g_addr, g_wdata;
  logic [1:0]                     rsp_valid_q;
  logic                           rsp_err_q, rsp_load_q;
  logic [2:0]                     rsp_funct3_q;
  logic [1:0]                     rsp_off_q;
  logic [DATA_WIDTH-1:0]          fmt_data;

  assign last_word = (cnt == DATA_MEM_ADDR_WIDTH'(DATA_MEM_DEPTH - 1));

  // rr_ptr names the port that wins when both request at once.
  always_comb begin
    gnt_any  = |req_valid_i;
    gnt_id   = (&req_valid_i) ? rr_ptr : req_valid_i[1];
    g_we     = gnt_id ? req_we_i[1] : req_we_i[0];
    g_funct3 = gnt_id ? req_funct3_i[5:3] : req_funct3_i[2:0];
    g_addr   = gnt_id ? req_addr_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_addr_i[DATA_WIDTH-1:0];
    g_wdata  = gnt_id ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
    g_ok     = access_ok(g_we, g_funct3, g_addr[1:0]);
  end

  // Outputs are gated by rst_n so they drop the moment reset is asserted.
  always_comb begin
    state_n      = state;
    req_ready_o  = 2'b00;
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    mem_funct3_o = 3'b000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    init_done_o  = 1'b0;
    if (rst_n) begin
      case (state)
        ARB_INIT: begin
          mem_we_o     = 1'b1;
          mem_funct3_o = FUNCT3_SW;
          mem_addr_o   = DATA_WIDTH'(cnt) << 2;
          if (last_word) state_n = ARB_RUN;
        end
        ARB_RUN: begin
          init_done_o = 1'b1;
          if (gnt_any) begin
            req_ready_o[gnt_id] = 1'b1;
            mem_we_o            = g_we & g_ok;
            mem_re_o            = ~g_we & g_ok;
            mem_funct3_o        = g_funct3;
            mem_addr_o          = g_addr;
            mem_wdata_o         = g_wdata;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR_ON_RESET ? ARB_INIT : ARB_RUN;
      cnt          <= '0;
      rr_ptr       <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_funct3_q <= 3'b000;
      rsp_off_q    <= 2'b00;
    end else begin
      state       <= state_n;
      rsp_valid_q <= 2'b00;
      if (state == ARB_INIT) cnt <= cnt + 1'b1;
      if (state == ARB_RUN && gnt_any) begin
        rr_ptr              <= ~gnt_id;
        rsp_valid_q[gnt_id] <= 1'b1;
        rsp_err_q           <= ~g_ok;
        rsp_load_q          <= ~g_we;
        rsp_funct3_q        <= g_funct3;
        rsp_off_q           <= g_addr[1:0];
      end
    end
  end

  load_formatter #(.WIDTH(DATA_WIDTH)) u_load_formatter (
    .funct3   (rsp_funct3_q),
    .byte_off (rsp_off_q),
    .raw      (mem_rdata_i),
    .data     (fmt_data)
  );

  assign resp_valid_o = rsp_valid_q;
  assign resp_err_o   = (|rsp_valid_q) & rsp_err_q;
  assign resp_rdata_o = ((|rsp_valid_q) && rsp_load_q && !rsp_err_q) ? fmt_data : '0;

endmodule
